// File: rtl/piezo_tone_detector_pkg.sv
// Shared encodings and tone constants for the piezo audio path (the sound unit
// uses the same half-period counts as its toggle periods).
package piezo_tone_detector_pkg;

    localparam logic [1:0] CLASS_SILENT = 2'd0;
    localparam logic [1:0] CLASS_HORN   = 2'd1;
    localparam logic [1:0] CLASS_CLICK  = 2'd2;
    localparam logic [1:0] CLASS_NOISE  = 2'd3;

    typedef enum logic [1:0] {
        ST_SILENT  = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    localparam int HORN_HALF_CYC  = 62501;
    localparam int CLICK_HALF_CYC = 25001;
    localparam int CNT_W          = 23;

    // Inclusive |hp - nom| <= tol, done on 24 bits so the difference never wraps.
    function automatic logic in_window(input logic [CNT_W-1:0] hp,
                                       input logic [CNT_W:0]   nom,
                                       input logic [CNT_W:0]   tol);
        logic [CNT_W:0] hp_ext;
        logic [CNT_W:0] diff;
        hp_ext = {1'b0, hp};
        diff   = (hp_ext >= nom) ? (hp_ext - nom) : (nom - hp_ext);
        return (diff <= tol);
    endfunction

endpackage

// File: rtl/piezo_tone_detector_edge_sync3.sv
// Two-flop synchronizer plus delay flop; pulses for one cycle on either
// transition of the asynchronous input.
module edge_sync3 (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic edge_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], async_i};
        end
    end

    assign edge_o = sync_q[1] ^ sync_q[2];

endmodule

// File: rtl/piezo_tone_detector.sv
// Half-period meter and tone classifier for a square-wave piezo line:
// SILENT / HORN / CLICK / NOISE with run-length locking and silence timeout.
module piezo_tone_detector
    import piezo_tone_detector_pkg::*;
#(
    parameter int HORN_HALF   = HORN_HALF_CYC,
    parameter int CLICK_HALF  = CLICK_HALF_CYC,
    parameter int TOL         = 1024,
    parameter int STABLE_N    = 4,
    parameter int SILENCE_CYC = 4194304
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             audio_in,
    output logic [1:0]       tone_class,
    output logic             class_change,
    output logic [CNT_W-1:0] half_period,
    output logic             hp_valid,
    output logic             locked
);

    localparam logic [CNT_W:0]   HORN_W   = (CNT_W+1)'(HORN_HALF);
    localparam logic [CNT_W:0]   CLICK_W  = (CNT_W+1)'(CLICK_HALF);
    localparam logic [CNT_W:0]   TOL_W    = (CNT_W+1)'(TOL);
    localparam logic [CNT_W-1:0] SIL_W    = CNT_W'(SILENCE_CYC);
    localparam logic [2:0]       STABLE_W = 3'(STABLE_N);

    logic             edge_w;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       run_q;
    logic [1:0]       prev_bin_q;
    logic [1:0]       tone_class_q;
    logic             class_change_q;
    logic [CNT_W-1:0] half_period_q;
    logic             hp_valid_q;
    logic             locked_q;

    logic [1:0]       hp_bin_d;
    logic [2:0]       run_d;
    logic [1:0]       class_d;
    logic             timeout_d;

    edge_sync3 u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (audio_in),
        .edge_o  (edge_w)
    );

    // Bin the current count; only meaningful in cycles where an edge closes it.
    always_comb begin
        hp_bin_d = CLASS_NOISE;
        if (in_window(cnt_q, HORN_W, TOL_W)) begin
            hp_bin_d = CLASS_HORN;
        end else if (in_window(cnt_q, CLICK_W, TOL_W)) begin
            hp_bin_d = CLASS_CLICK;
        end

        run_d = 3'd1;
        if (hp_bin_d == prev_bin_q) begin
            run_d = (run_q >= STABLE_W) ? run_q : run_q + 3'd1;
        end

        timeout_d = (state_q != ST_SILENT) && !edge_w && (cnt_q == SIL_W);

        class_d = tone_class_q;
        if (state_q != ST_SILENT && edge_w) begin
            if (run_d == STABLE_W) begin
                class_d = hp_bin_d;
            end
        end else if (timeout_d) begin
            class_d = CLASS_SILENT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_SILENT;
            cnt_q          <= '0;
            run_q          <= 3'd0;
            prev_bin_q     <= 2'd0;
            tone_class_q   <= CLASS_SILENT;
            class_change_q <= 1'b0;
            half_period_q  <= '0;
            hp_valid_q     <= 1'b0;
            locked_q       <= 1'b0;
        end else begin
            hp_valid_q <= 1'b0;
            case (state_q)
                ST_SILENT: begin
                    // Start edge only: arms the counter, nothing is recorded.
                    cnt_q <= '0;
                    if (edge_w) begin
                        cnt_q   <= CNT_W'(1);
                        state_q <= ST_ARMED;
                    end
                end
                default: begin
                    if (edge_w) begin
                        cnt_q         <= CNT_W'(1);
                        half_period_q <= cnt_q;
                        hp_valid_q    <= 1'b1;
                        prev_bin_q    <= hp_bin_d;
                        run_q         <= run_d;
                        state_q       <= ST_MEASURE;
                    end else if (timeout_d) begin
                        cnt_q      <= '0;
                        run_q      <= 3'd0;
                        prev_bin_q <= 2'd0;
                        state_q    <= ST_SILENT;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            endcase
            tone_class_q   <= class_d;
            class_change_q <= (class_d != tone_class_q);
            locked_q       <= (class_d != CLASS_SILENT);
        end
    end

    assign tone_class   = tone_class_q;
    assign class_change = class_change_q;
    assign half_period  = half_period_q;
    assign hp_valid     = hp_valid_q;
    assign locked       = locked_q;

endmodule
